// File: rtl/mmio_uart_ctrl.sv
// MEM-stage MMIO controller: UART RX FIFO, single-entry TX holding register,
// cycle/instruction counters and a registered read port aligned with WB.
module mmio_uart_ctrl #(
   parameter int          RX_FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE     = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic        inst_retired,
   input  logic [7:0]  uart_rx_data_out,
   input  logic        uart_rx_data_out_valid,
   output logic        uart_rx_data_out_ready,
   output logic [7:0]  uart_tx_data_in,
   output logic        uart_tx_data_in_valid,
   input  logic        uart_tx_data_in_ready
);

   localparam int PW = $clog2(RX_FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [31:0] A_STATUS = MMIO_BASE + 32'h00;
   localparam logic [31:0] A_RXDATA = MMIO_BASE + 32'h04;
   localparam logic [31:0] A_TXDATA = MMIO_BASE + 32'h08;
   localparam logic [31:0] A_CYCLE  = MMIO_BASE + 32'h10;
   localparam logic [31:0] A_INST   = MMIO_BASE + 32'h14;
   localparam logic [31:0] A_CNTRST = MMIO_BASE + 32'h18;

   logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] rx_count;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_overrun;
   logic [31:0]   cycle_count;
   logic [31:0]   inst_count;

   logic        load;
   logic        store;
   logic        rx_empty;
   logic        rx_full;
   logic        push;
   logic        pop;
   logic        drain;
   logic        tx_store;
   logic        tx_accept;
   logic        status_rd;
   logic        cnt_clr;
   logic [31:0] status_word;
   logic [31:0] rd_data;
   logic        unused_din;

   assign load      = en & ~we;
   assign store     = en & we;
   assign rx_empty  = (rx_count == '0);
   assign rx_full   = (rx_count == CW'(RX_FIFO_DEPTH));
   assign push      = uart_rx_data_out_valid & uart_rx_data_out_ready;
   assign pop       = load & (addr == A_RXDATA) & ~rx_empty;
   assign drain     = tx_valid & uart_tx_data_in_ready;
   assign tx_store  = store & (addr == A_TXDATA);
   // A store may refill the holding register in the same cycle it drains.
   assign tx_accept = tx_store & (~tx_valid | drain);
   assign status_rd = load & (addr == A_STATUS);
   assign cnt_clr   = store & (addr == A_CNTRST);
   assign unused_din = ^din[31:8];

   assign uart_rx_data_out_ready = ~rx_full;
   assign uart_tx_data_in        = tx_data;
   assign uart_tx_data_in_valid  = tx_valid;

   assign status_word = {29'd0, tx_overrun, ~rx_empty, ~tx_valid};

   always_comb begin
      rd_data = '0;
      case (addr)
         A_STATUS: rd_data = status_word;
         A_RXDATA: rd_data = rx_empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr]};
         A_CYCLE:  rd_data = cycle_count;
         A_INST:   rd_data = inst_count;
         default:  rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= uart_rx_data_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         rx_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)      rx_count <= rx_count + 1'b1;
         else if (pop & ~push) rx_count <= rx_count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_valid   <= 1'b0;
         tx_data    <= 8'd0;
         tx_overrun <= 1'b0;
      end else begin
         if (tx_accept) begin
            tx_valid <= 1'b1;
            tx_data  <= din[7:0];
         end else if (drain) begin
            tx_valid <= 1'b0;
         end
         // A fresh overrun outranks the clear-on-read of status.
         if (tx_store & ~tx_accept) tx_overrun <= 1'b1;
         else if (status_rd)        tx_overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_count <= '0;
         inst_count  <= '0;
      end else if (cnt_clr) begin
         cycle_count <= '0;
         inst_count  <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (inst_retired) inst_count <= inst_count + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       dout <= '0;
      else if (load) dout <= rd_data;
   end

endmodule
